rvh_l1d_snp_resp_tx: RTL and testbench

- Transmit side of the L1D snoop interface: once the snoop control path has looked up a snooped line, this block returns the result to the interconnect on the ACE-style CR (snoop response) and CD (snoop data) channels.
- Takes one resolved snoop result per handshake and drives the crresp bits.
- When data transfer is required, serialises the cache line into CD beats with cdlast.
- Sits between the L1D snoop control / snoop request buffer and the cache-memory interface.

---
 rtl/rvh_l1d_snp_resp_tx.sv | 128 ++++++++++++
 tb/tb_rvh_l1d_snp_resp_tx.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvh_l1d_snp_resp_tx.sv
// Snoop response transmitter: one resolved snoop result in, a CR response and an optional CD line burst out.
// Latency: CR/CD valid 1 cycle after accept. Backpressure: CR and CD stall independently; accept only when idle (or skid empty).
// Optional macro RVH_L1D_SNP_RESP_SKID_EN adds a one-entry input skid buffer so the next result launches with no idle bubble.
module rvh_l1d_snp_resp_tx #(
    parameter int LINE_W = 512,
    parameter int CD_W   = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              snp_resp_vld_i,
    output logic              snp_resp_rdy_o,
    input  logic              snp_resp_data_transfer_i,
    input  logic              snp_resp_is_dirty_i,
    input  logic              snp_resp_is_shared_i,
    input  logic              snp_resp_was_unique_i,
    input  logic [LINE_W-1:0] snp_resp_line_i,
    output logic              cr_vld_o,
    input  logic              cr_rdy_i,
    output logic [4:0]        crresp_o,
    output logic              cd_vld_o,
    input  logic              cd_rdy_i,
    output logic [CD_W-1:0]   cddata_o,
    output logic              cdlast_o
);
    localparam int BEATS = LINE_W / CD_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;

    logic                        state_q;
    logic [CNT_W-1:0]            cnt_q;
    logic                        cr_vld_q, cd_vld_q, cr_done_q, cd_done_q;
    logic [4:0]                  crresp_q;
    logic [BEATS-1:0][CD_W-1:0]  line_q;

    logic              in_acc, launch, cd_hs, cd_last_hs, cr_done_n, cd_done_n, finish;
    logic [4:0]        in_resp, launch_resp;
    logic [LINE_W-1:0] launch_line;

    // crresp bit order: {WasUnique, IsShared, PassDirty, Error, DataTransfer}
    assign in_resp = {snp_resp_was_unique_i, snp_resp_is_shared_i,
                      snp_resp_is_dirty_i & snp_resp_data_transfer_i, 1'b0,
                      snp_resp_data_transfer_i};
    assign in_acc  = snp_resp_vld_i & snp_resp_rdy_o;

    assign cd_hs      = cd_vld_q & cd_rdy_i;
    assign cd_last_hs = cd_hs & (cnt_q == LAST_CNT);
    assign cr_done_n  = cr_done_q | (cr_vld_q & cr_rdy_i);
    assign cd_done_n  = cd_done_q | cd_last_hs;
    assign finish     = (state_q == BUSY) & cr_done_n & cd_done_n;

`ifdef RVH_L1D_SNP_RESP_SKID_EN
    logic              skid_vld_q;
    logic [4:0]        skid_resp_q;
    logic [LINE_W-1:0] skid_line_q;
    logic              skid_wr;

    assign snp_resp_rdy_o = ~skid_vld_q;
    assign launch      = ((state_q == IDLE) | finish) & (skid_vld_q | in_acc);
    assign launch_resp = skid_vld_q ? skid_resp_q : in_resp;
    assign launch_line = skid_vld_q ? skid_line_q : snp_resp_line_i;
    // Input only parks in the buffer when it cannot go straight to the FSM
    assign skid_wr     = in_acc & ~(launch & ~skid_vld_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_vld_q  <= 1'b0;
            skid_resp_q <= '0;
            skid_line_q <= '0;
        end else if (skid_wr) begin
            skid_vld_q  <= 1'b1;
            skid_resp_q <= in_resp;
            skid_line_q <= snp_resp_line_i;
        end else if (launch) begin
            skid_vld_q  <= 1'b0;
        end
    end
`else
    assign snp_resp_rdy_o = (state_q == IDLE);
    assign launch      = in_acc;
    assign launch_resp = in_resp;
    assign launch_line = snp_resp_line_i;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cr_vld_q  <= 1'b0;
            cd_vld_q  <= 1'b0;
            cr_done_q <= 1'b0;
            cd_done_q <= 1'b0;
            crresp_q  <= '0;
            line_q    <= '0;
        end else begin
            cr_done_q <= cr_done_n;
            cd_done_q <= cd_done_n;
            if (cr_vld_q && cr_rdy_i) cr_vld_q <= 1'b0;
            if (cd_hs) begin
                if (cnt_q == LAST_CNT) begin
                    cnt_q    <= '0;
                    cd_vld_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            if (finish) state_q <= IDLE;
            // A launch in the finishing cycle overrides the return to IDLE
            if (launch) begin
                state_q   <= BUSY;
                crresp_q  <= launch_resp;
                line_q    <= launch_line;
                cr_vld_q  <= 1'b1;
                cd_vld_q  <= launch_resp[0];
                cr_done_q <= 1'b0;
                cd_done_q <= ~launch_resp[0];
                cnt_q     <= '0;
            end
        end
    end

    assign cr_vld_o = cr_vld_q;
    assign crresp_o = crresp_q;
    assign cd_vld_o = cd_vld_q;
    assign cddata_o = line_q[cnt_q];
    assign cdlast_o = cd_vld_q & (cnt_q == LAST_CNT);
endmodule

// File: tb/tb_rvh_l1d_snp_resp_tx.sv
// Self-checking bench for rvh_l1d_snp_resp_tx: scoreboard queues for CR/CD plus per-scenario timing checks.
module tb_rvh_l1d_snp_resp_tx;
    localparam int LINE_W = 512;
    localparam int CD_W   = 128;
    localparam int BEATS  = LINE_W / CD_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              snp_resp_vld_i = 1'b0;
    logic              snp_resp_rdy_o;
    logic              snp_resp_data_transfer_i = 1'b0;
    logic              snp_resp_is_dirty_i = 1'b0;
    logic              snp_resp_is_shared_i = 1'b0;
    logic              snp_resp_was_unique_i = 1'b0;
    logic [LINE_W-1:0] snp_resp_line_i = '0;
    logic              cr_vld_o;
    logic              cr_rdy_i = 1'b0;
    logic [4:0]        crresp_o;
    logic              cd_vld_o;
    logic              cd_rdy_i = 1'b0;
    logic [CD_W-1:0]   cddata_o;
    logic              cdlast_o;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    logic [4:0]    cr_q[$];
    logic [CD_W:0] cd_q[$];

    rvh_l1d_snp_resp_tx #(.LINE_W(LINE_W), .CD_W(CD_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .snp_resp_vld_i(snp_resp_vld_i), .snp_resp_rdy_o(snp_resp_rdy_o),
        .snp_resp_data_transfer_i(snp_resp_data_transfer_i),
        .snp_resp_is_dirty_i(snp_resp_is_dirty_i),
        .snp_resp_is_shared_i(snp_resp_is_shared_i),
        .snp_resp_was_unique_i(snp_resp_was_unique_i),
        .snp_resp_line_i(snp_resp_line_i),
        .cr_vld_o(cr_vld_o), .cr_rdy_i(cr_rdy_i), .crresp_o(crresp_o),
        .cd_vld_o(cd_vld_o), .cd_rdy_i(cd_rdy_i), .cddata_o(cddata_o), .cdlast_o(cdlast_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: handshakes sampled at negedge, inputs only change 2ns after posedge
    always @(negedge clk) begin
        if (rst_n && cr_vld_o && cr_rdy_i) begin
            compared++;
            if (cr_q.size() == 0) begin
                mismatched++;
                $display("FAIL cr_unexpected: got crresp=%b, expected no response", crresp_o);
            end else begin
                logic [4:0] e;
                e = cr_q.pop_front();
                if (crresp_o !== e) begin
                    mismatched++;
                    $display("FAIL cr_resp: got %b expected %b", crresp_o, e);
                end
            end
        end
        if (rst_n && cd_vld_o && cd_rdy_i) begin
            compared++;
            if (cd_q.size() == 0) begin
                mismatched++;
                $display("FAIL cd_unexpected: got data=%h last=%b, expected no beat", cddata_o, cdlast_o);
            end else begin
                logic [CD_W:0] e;
                e = cd_q.pop_front();
                if ({cdlast_o, cddata_o} !== e) begin
                    mismatched++;
                    $display("FAIL cd_beat: got last=%b data=%h expected last=%b data=%h",
                             cdlast_o, cddata_o, e[CD_W], e[CD_W-1:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [LINE_W-1:0] mk_line(input logic [CD_W-1:0] b0, b1, b2, b3);
        return {b3, b2, b1, b0};
    endfunction

    // Leaves vld high on return (just after the accepting edge); caller drops it
    task automatic send(input logic dt, dirty, shared, uniq, input logic [LINE_W-1:0] line,
                        output int acc_cyc);
        int n = 0;
        logic [LINE_W-1:0] l;
        snp_resp_data_transfer_i = dt;
        snp_resp_is_dirty_i      = dirty;
        snp_resp_is_shared_i     = shared;
        snp_resp_was_unique_i    = uniq;
        snp_resp_line_i          = line;
        snp_resp_vld_i           = 1'b1;
        l = line;
        while (!snp_resp_rdy_o && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: rdy=%b, expected 1 within 100 cycles", snp_resp_rdy_o);
        end
        @(posedge clk);
        acc_cyc = cyc;
        cr_q.push_back({uniq, shared, dirty & dt, 1'b0, dt});
        if (dt)
            for (int b = 0; b < BEATS; b++)
                cd_q.push_back({(b == BEATS - 1), l[b*CD_W +: CD_W]});
        #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!snp_resp_rdy_o && n < 200) begin
            step();
            n++;
        end
        compared++;
        if (!snp_resp_rdy_o) begin
            mismatched++;
            $display("FAIL idle_timeout: rdy=%b expected 1", snp_resp_rdy_o);
        end
    endtask

    task automatic test_reset();
        #1;
        compared++;
        if ({cr_vld_o, cd_vld_o, cdlast_o, crresp_o, cddata_o} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: cr_vld=%b cd_vld=%b last=%b crresp=%b data=%h expected all 0",
                     cr_vld_o, cd_vld_o, cdlast_o, crresp_o, cddata_o);
        end
        step();
        rst_n = 1'b1;
        step();
        compared++;
        if (snp_resp_rdy_o !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_rdy: got %b expected 1", snp_resp_rdy_o);
        end
    endtask

    task automatic test_no_data();
        int a;
        cr_rdy_i = 1'b1;
        cd_rdy_i = 1'b1;
        send(1'b0, 1'b0, 1'b0, 1'b1, '0, a);
        snp_resp_vld_i = 1'b0;
        compared++;
        if ({cr_vld_o, crresp_o, cd_vld_o, snp_resp_rdy_o} !== {1'b1, 5'b10000, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL nodata_n1: got cr_vld=%b crresp=%b cd_vld=%b rdy=%b expected 1 10000 0 0",
                     cr_vld_o, crresp_o, cd_vld_o, snp_resp_rdy_o);
        end
        step();
        compared++;
        if ({snp_resp_rdy_o, cr_vld_o, cd_vld_o} !== 3'b100) begin
            mismatched++;
            $display("FAIL nodata_n2: got rdy=%b cr_vld=%b cd_vld=%b expected 1 0 0",
                     snp_resp_rdy_o, cr_vld_o, cd_vld_o);
        end
    endtask

    task automatic test_dirty_line();
        int a;
        cr_rdy_i = 1'b1;
        cd_rdy_i = 1'b1;
        send(1'b1, 1'b1, 1'b0, 1'b0, mk_line('hA, 'hB, 'hC, 'hD), a);
        snp_resp_vld_i = 1'b0;
        compared++;
        if (crresp_o !== 5'b00101) begin
            mismatched++;
            $display("FAIL dirty_crresp: got %b expected 00101", crresp_o);
        end
        for (int i = 0; i < BEATS; i++) begin
            compared++;
            if (cd_vld_o !== 1'b1 || snp_resp_rdy_o !== 1'b0) begin
                mismatched++;
                $display("FAIL dirty_burst_%0d: got cd_vld=%b rdy=%b expected 1 0", i, cd_vld_o, snp_resp_rdy_o);
            end
            step();
        end
        compared++;
        if (snp_resp_rdy_o !== 1'b1 || cd_vld_o !== 1'b0) begin
            mismatched++;
            $display("FAIL dirty_idle: got rdy=%b cd_vld=%b expected 1 0", snp_resp_rdy_o, cd_vld_o);
        end
    endtask

    task automatic test_cd_backpressure();
        int a;
        cr_rdy_i = 1'b1;
        cd_rdy_i = 1'b1;
        send(1'b1, 1'b0, 1'b1, 1'b0, mk_line('hA, 'hB, 'hC, 'hD), a);
        snp_resp_vld_i = 1'b0;
        step();
        cd_rdy_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            compared++;
            if ({cd_vld_o, cdlast_o, cddata_o} !== {1'b1, 1'b0, CD_W'('hB)}) begin
                mismatched++;
                $display("FAIL bp_hold_%0d: got vld=%b last=%b data=%h expected 1 0 b",
                         i, cd_vld_o, cdlast_o, cddata_o);
            end
            step();
        end
        cd_rdy_i = 1'b1;
        wait_idle();
    endtask

    task automatic test_cr_stall();
        int a;
        cr_rdy_i = 1'b0;
        cd_rdy_i = 1'b1;
        send(1'b1, 1'b0, 1'b0, 1'b1, mk_line('h11, 'h22, 'h33, 'h44), a);
        snp_resp_vld_i = 1'b0;
        for (int i = 0; i < BEATS + 1; i++) step();
        compared++;
        if ({cd_vld_o, cr_vld_o, snp_resp_rdy_o} !== 3'b010) begin
            mismatched++;
            $display("FAIL crstall_busy: got cd_vld=%b cr_vld=%b rdy=%b expected 0 1 0",
                     cd_vld_o, cr_vld_o, snp_resp_rdy_o);
        end
        cr_rdy_i = 1'b1;
        step();
        compared++;
        if ({snp_resp_rdy_o, cr_vld_o} !== 2'b10) begin
            mismatched++;
            $display("FAIL crstall_release: got rdy=%b cr_vld=%b expected 1 0", snp_resp_rdy_o, cr_vld_o);
        end
    endtask

    task automatic test_reset_mid_burst();
        int a;
        cr_rdy_i = 1'b1;
        cd_rdy_i = 1'b1;
        send(1'b1, 1'b1, 1'b0, 1'b1, mk_line('hA, 'hB, 'hC, 'hD), a);
        snp_resp_vld_i = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        cd_q.delete();
        #1;
        compared++;
        if ({cr_vld_o, cd_vld_o, cdlast_o, cddata_o} !== '0) begin
            mismatched++;
            $display("FAIL midrst_outputs: got cr_vld=%b cd_vld=%b last=%b data=%h expected all 0",
                     cr_vld_o, cd_vld_o, cdlast_o, cddata_o);
        end
        step();
        rst_n = 1'b1;
        step();
        send(1'b1, 1'b0, 1'b0, 1'b0, mk_line('h1, 'h2, 'h3, 'h4), a);
        snp_resp_vld_i = 1'b0;
        compared++;
        if (cddata_o !== CD_W'('h1)) begin
            mismatched++;
            $display("FAIL midrst_beat0: got %h expected 1", cddata_o);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int a1, a2, exp_gap;
`ifdef RVH_L1D_SNP_RESP_SKID_EN
        exp_gap = 1;
`else
        exp_gap = 2;
`endif
        cr_rdy_i = 1'b1;
        cd_rdy_i = 1'b1;
        send(1'b0, 1'b0, 1'b0, 1'b1, '0, a1);
        send(1'b0, 1'b0, 1'b1, 1'b0, '0, a2);
        snp_resp_vld_i = 1'b0;
        compared++;
        if (a2 - a1 !== exp_gap) begin
            mismatched++;
            $display("FAIL b2b_gap: got %0d cycles expected %0d", a2 - a1, exp_gap);
        end
        compared++;
        if ({cr_vld_o, crresp_o} !== {1'b1, 5'b01000}) begin
            mismatched++;
            $display("FAIL b2b_second_cr: got cr_vld=%b crresp=%b expected 1 01000", cr_vld_o, crresp_o);
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_no_data();
        test_dirty_line();
        test_cd_backpressure();
        test_cr_stall();
        test_reset_mid_burst();
        test_back_to_back();
        step();
        step();
        compared++;
        if (cr_q.size() != 0 || cd_q.size() != 0) begin
            mismatched++;
            $display("FAIL sb_drain: got %0d cr / %0d cd pending expected 0 / 0", cr_q.size(), cd_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
